// File: rtl/riscv_nn_defines.sv
// ============================================================================
// Module   : riscv_nn_defines (package)
// Brief    : Shared hardware-loop definitions: write-enable bit indices and
//            the per-set write-strobe decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_nn_defines;

  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

  typedef struct packed {
    logic cnt;
    logic end_addr;
    logic start;
  } hwlp_we_t;

  // A field is written only when the instruction is valid and targets this set.
  function automatic hwlp_we_t hwlp_we_decode(input logic [2:0] we,
                                              input logic       hit,
                                              input logic       valid);
    hwlp_we_t res;
    res.start    = we[HWLP_WE_START] & hit & valid;
    res.end_addr = we[HWLP_WE_END]   & hit & valid;
    res.cnt      = we[HWLP_WE_CNT]   & hit & valid;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_nn_hwloop_regs_regset.sv
// ============================================================================
// Module   : riscv_nn_hwloop_regset
// Brief    : One hardware-loop register set (start, end, counter, active).
//            Optional macro HWLP_CNT_SATURATE_EN: decrement at 0 holds 0
//            instead of wrapping to 32'hFFFF_FFFF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_nn_hwloop_regset
  import riscv_nn_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  hwlp_we_t    we,
  input  logic        dec,
  input  logic [31:0] start_data,
  input  logic [31:0] end_data,
  input  logic [31:0] cnt_data,
  output logic [31:0] start_addr,
  output logic [31:0] end_addr,
  output logic [31:0] counter,
  output logic        active
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_addr <= 32'h0;
      end_addr   <= 32'h0;
      counter    <= 32'h0;
      active     <= 1'b0;
    end else begin
      if (we.start)    start_addr <= start_data;
      if (we.end_addr) end_addr   <= end_data;
      // A counter write wins over a same-set decrement.
      if (we.cnt) begin
        counter <= cnt_data;
        active  <= |cnt_data;
      end else if (dec) begin
        if (counter == 32'h0) begin
`ifdef HWLP_CNT_SATURATE_EN
          counter <= 32'h0;
`else
          counter <= 32'hFFFF_FFFF;
`endif
        end else begin
          counter <= counter - 32'd1;
          if (counter == 32'd1) active <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_nn_hwloop_regs.sv
// ============================================================================
// Module   : riscv_nn_hwloop_regs
// Brief    : Array of N_REGS hardware-loop register sets with write and
//            decrement ports. Honours macro HWLP_CNT_SATURATE_EN (in regset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_nn_hwloop_regs
  import riscv_nn_defines::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            hwlp_start_data_i,
  input  logic [31:0]            hwlp_end_data_i,
  input  logic [31:0]            hwlp_cnt_data_i,
  input  logic [2:0]             hwlp_we_i,
  input  logic [N_REG_BITS-1:0]  hwlp_regid_i,
  input  logic                   valid_i,
  input  logic [N_REGS-1:0]      hwlp_dec_cnt_i,
  output logic [N_REGS-1:0][31:0] hwlp_start_addr_o,
  output logic [N_REGS-1:0][31:0] hwlp_end_addr_o,
  output logic [N_REGS-1:0][31:0] hwlp_counter_o,
  output logic [N_REGS-1:0]      hwlp_active_o
);

  for (genvar k = 0; k < N_REGS; k++) begin : g_regset
    hwlp_we_t w_we;
    logic     w_dec;

    assign w_we  = hwlp_we_decode(hwlp_we_i, hwlp_regid_i == N_REG_BITS'(k), valid_i);
    assign w_dec = valid_i & hwlp_dec_cnt_i[k];

    riscv_nn_hwloop_regset u_regset (
      .clk        (clk),
      .rst        (rst),
      .we         (w_we),
      .dec        (w_dec),
      .start_data (hwlp_start_data_i),
      .end_data   (hwlp_end_data_i),
      .cnt_data   (hwlp_cnt_data_i),
      .start_addr (hwlp_start_addr_o[k]),
      .end_addr   (hwlp_end_addr_o[k]),
      .counter    (hwlp_counter_o[k]),
      .active     (hwlp_active_o[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_nn_hwloop_regs.sv
// ============================================================================
// Module   : tb_riscv_nn_hwloop_regs
// Brief    : Directed plus random scoreboard bench for riscv_nn_hwloop_regs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_nn_hwloop_regs;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      start_d, end_d, cnt_d;
  logic [2:0]       we;
  logic [0:0]       regid;
  logic             valid;
  logic [1:0]       dec;
  logic [1:0][31:0] start_o, end_o, cnt_o;
  logic [1:0]       act_o;

  typedef struct packed {
    logic [1:0][31:0] s;
    logic [1:0][31:0] e;
    logic [1:0][31:0] c;
    logic [1:0]       a;
  } exp_t;

  exp_t model;
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  riscv_nn_hwloop_regs dut (
    .clk               (clk),
    .rst               (rst),
    .hwlp_start_data_i (start_d),
    .hwlp_end_data_i   (end_d),
    .hwlp_cnt_data_i   (cnt_d),
    .hwlp_we_i         (we),
    .hwlp_regid_i      (regid),
    .valid_i           (valid),
    .hwlp_dec_cnt_i    (dec),
    .hwlp_start_addr_o (start_o),
    .hwlp_end_addr_o   (end_o),
    .hwlp_counter_o    (cnt_o),
    .hwlp_active_o     (act_o)
  );

  task automatic check_all(input exp_t ex, input string tag);
    for (int k = 0; k < 2; k++) begin
      checks++;
      assert (start_o[k] === ex.s[k]) else begin
        errors++;
        $error("FAIL %s start[%0d] observed=%h expected=%h", tag, k, start_o[k], ex.s[k]);
      end
      checks++;
      assert (end_o[k] === ex.e[k]) else begin
        errors++;
        $error("FAIL %s end[%0d] observed=%h expected=%h", tag, k, end_o[k], ex.e[k]);
      end
      checks++;
      assert (cnt_o[k] === ex.c[k]) else begin
        errors++;
        $error("FAIL %s cnt[%0d] observed=%h expected=%h", tag, k, cnt_o[k], ex.c[k]);
      end
      checks++;
      assert (act_o[k] === ex.a[k]) else begin
        errors++;
        $error("FAIL %s active[%0d] observed=%b expected=%b", tag, k, act_o[k], ex.a[k]);
      end
    end
  endtask

  // Drive one cycle of stimulus, predict its effect, compare after the edge.
  task automatic step(input logic [2:0] w, input logic id, input logic [31:0] sd,
                      input logic [31:0] ed, input logic [31:0] cd, input logic v,
                      input logic [1:0] dc, input string tag);
    exp_t ex;
    we = w; regid = id; start_d = sd; end_d = ed; cnt_d = cd; valid = v; dec = dc;
    if (v) begin
      for (int k = 0; k < 2; k++) begin
        if (w[0] && id == k[0]) model.s[k] = sd;
        if (w[1] && id == k[0]) model.e[k] = ed;
        if (w[2] && id == k[0]) begin
          model.c[k] = cd;
          model.a[k] = (cd != 32'd0);
        end else if (dc[k]) begin
          if (model.c[k] == 32'd0) begin
`ifdef HWLP_CNT_SATURATE_EN
            model.c[k] = 32'd0;
`else
            model.c[k] = 32'hFFFF_FFFF;
`endif
          end else begin
            if (model.c[k] == 32'd1) model.a[k] = 1'b0;
            model.c[k] = model.c[k] - 32'd1;
          end
        end
      end
    end
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      ex = sb_q.pop_front();
      check_all(ex, tag);
    end
  endtask

  initial begin
    model = '0;
    rst = 1'b1; we = 3'b000; regid = 1'b0; start_d = '0; end_d = '0; cnt_d = '0;
    valid = 1'b0; dec = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_all(model, "reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    step(3'b111, 1'b1, 32'h100, 32'h120, 32'd5, 1'b1, 2'b00, "setup");
    step(3'b100, 1'b0, 32'h0, 32'h0, 32'd2, 1'b1, 2'b00, "cd_load");
    step(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b01, "cd_1");
    step(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b01, "cd_0");
    step(3'b100, 1'b0, 32'h0, 32'h0, 32'd7, 1'b1, 2'b00, "col_load");
    step(3'b100, 1'b0, 32'h0, 32'h0, 32'd3, 1'b1, 2'b01, "collision");
    step(3'b100, 1'b1, 32'h0, 32'h0, 32'd9, 1'b1, 2'b01, "cross_wr_dec");
    step(3'b100, 1'b0, 32'h0, 32'h0, 32'd55, 1'b0, 2'b11, "gated");
    step(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b11, "dual_dec");
    step(3'b011, 1'b1, 32'hA00, 32'hB00, 32'd0, 1'b1, 2'b00, "se_keep_active");
    step(3'b100, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b00, "wr_zero");
    step(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b01, "zero_dec");
    step(3'b111, 1'b0, 32'h40, 32'h80, 32'd3, 1'b1, 2'b00, "pre_rst_load");
    step(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b01, "pre_rst_dec");

    // Assert reset mid-cycle while decrementing; outputs must clear before the next edge.
    #2;
    rst = 1'b1;
    model = '0;
    #1;
    check_all(model, "async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b00, "post_rst");

    for (int i = 0; i < 20; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
           32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
